// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the two-port memory arbiter.
//   - state_t      : access sequencer states (IDLE grants, RESP returns data)
//   - PORT_CPU/AUX : port indices used for grant and current-owner tracking
//   - NPORTS       : number of requesters
//   - rr_pick()    : two-way round-robin choice given requests and last grant
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int unsigned NPORTS   = 2;
    localparam logic        PORT_CPU = 1'b0;
    localparam logic        PORT_AUX = 1'b1;

    // A lone requester always wins; on a tie the port that did not win last
    // time gets the grant.
    function automatic logic rr_pick(input logic [NPORTS-1:0] req,
                                     input logic              last_grant);
        logic pick;
        pick = PORT_CPU;
        case (req)
            2'b01:   pick = PORT_CPU;
            2'b10:   pick = PORT_AUX;
            2'b11:   pick = ~last_grant;
            default: pick = PORT_CPU;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// ---------------------------------------------------------------------------
// mem_rr_arb2
//   Two-way round-robin arbiter: combinational grant plus last-grant register.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     req        : request vector, bit n = port n valid
//     advance    : grant is being consumed this cycle; remember the winner
//     gnt_idx    : index of the winning port (meaningful when gnt_any)
//     gnt_any    : at least one request present
// ---------------------------------------------------------------------------
module mem_rr_arb2
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic              advance,
    output logic              gnt_idx,
    output logic              gnt_any
);

    logic r_last_grant;

    // Reset to the aux port so the CPU port wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= PORT_AUX;
        end else if (advance) begin
            r_last_grant <= gnt_idx;
        end
    end

    always_comb begin
        gnt_any = |req;
        gnt_idx = rr_pick(req, r_last_grant);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, synchronous-read word memory between the core
//   port (p0) and an auxiliary port (p1) using the valid/ready handshake.
//   Each access takes two cycles: grant + memory command (IDLE), then ready
//   with the registered read data (RESP). Writes return the pre-write word.
//   Ports:
//     clk, reset             : clock, synchronous active-high reset
//     p{0,1}_valid/addr/...  : requester command (byte address, data, strobes;
//                              wstrb == 0 means read)
//     p{0,1}_ready/rdata     : one-cycle completion pulse with read data
//     mem_wen/addr/wdata     : memory command (word address)
//     mem_rdata              : memory registered read data
//     busy                   : access in flight (RESP state)
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                p0_valid,
    input  logic [31:0]         p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_wstrb,
    output logic                p0_ready,
    output logic [DATA_W-1:0]   p0_rdata,

    input  logic                p1_valid,
    input  logic [31:0]         p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wstrb,
    output logic                p1_ready,
    output logic [DATA_W-1:0]   p1_rdata,

    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    state_t r_state;
    state_t w_next_state;
    logic   r_cur;
    logic   w_gnt_idx;
    logic   w_gnt_any;
    logic   w_advance;

    // Byte-offset bits and bits above the memory range are ignored so the
    // address space wraps on the memory size.
    logic   w_unused;
    assign w_unused = ^{p0_addr[31:ADDR_W+2], p0_addr[1:0],
                        p1_addr[31:ADDR_W+2], p1_addr[1:0]};

    assign w_advance = (r_state == IDLE) && w_gnt_any && !reset;

    mem_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({p1_valid, p0_valid}),
        .advance (w_advance),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    // State register and owner of the in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cur   <= PORT_CPU;
        end else begin
            r_state <= w_next_state;
            if (w_advance) begin
                r_cur <= w_gnt_idx;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_gnt_any ? RESP : IDLE;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs. Reset is folded in combinationally so an access aborted by
    // reset neither writes memory nor produces a ready in the reset cycle.
    always_comb begin
        mem_wen   = '0;
        mem_addr  = p0_addr[ADDR_W+1:2];
        mem_wdata = p0_wdata;
        p0_ready  = 1'b0;
        p1_ready  = 1'b0;
        p0_rdata  = '0;
        p1_rdata  = '0;
        busy      = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        if (w_gnt_idx == PORT_AUX) begin
                            mem_addr  = p1_addr[ADDR_W+1:2];
                            mem_wdata = p1_wdata;
                            mem_wen   = p1_wstrb;
                        end else begin
                            mem_wen   = p0_wstrb;
                        end
                    end
                end
                RESP: begin
                    busy = 1'b1;
                    if (r_cur == PORT_AUX) begin
                        p1_ready = 1'b1;
                        p1_rdata = mem_rdata;
                    end else begin
                        p0_ready = 1'b1;
                        p0_rdata = mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk;
    logic        reset;
    logic        p0_valid, p1_valid;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [3:0]  p0_wstrb, p1_wstrb;
    logic        p0_ready, p1_ready;
    logic [31:0] p0_rdata, p1_rdata;
    logic [3:0]  mem_wen;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;
    logic        tb_load;

    int n_checks;
    int n_errors;

    mem_port_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_valid  (p0_valid),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_wstrb  (p0_wstrb),
        .p0_ready  (p0_ready),
        .p0_rdata  (p0_rdata),
        .p1_valid  (p1_valid),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_wstrb  (p1_wstrb),
        .p1_ready  (p1_ready),
        .p1_rdata  (p1_rdata),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read word memory with byte write enables (read-before-write).
    logic [31:0] mem [0:31];
    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[2] <= 32'hDEAD_BEEF;
            mem[4] <= 32'hAABB_CCDD;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        rst;
        logic        p0v;
        logic [31:0] p0a;
        logic [31:0] p0wd;
        logic [3:0]  p0ws;
        logic        p1v;
        logic [31:0] p1a;
        logic [31:0] p1wd;
        logic [3:0]  p1ws;
        logic [3:0]  e_wen;
        logic [4:0]  e_addr;
        logic        chk_addr;
        logic        e_r0;
        logic [31:0] e_rd0;
        logic        e_r1;
        logic [31:0] e_rd1;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mkv(
        input logic rst,
        input logic p0v, input logic [31:0] p0a, input logic [31:0] p0wd, input logic [3:0] p0ws,
        input logic p1v, input logic [31:0] p1a, input logic [31:0] p1wd, input logic [3:0] p1ws,
        input logic [3:0] ewen, input logic [4:0] eaddr, input logic chka,
        input logic er0, input logic [31:0] erd0,
        input logic er1, input logic [31:0] erd1,
        input logic ebusy);
        vec_t v;
        v.rst = rst;
        v.p0v = p0v; v.p0a = p0a; v.p0wd = p0wd; v.p0ws = p0ws;
        v.p1v = p1v; v.p1a = p1a; v.p1wd = p1wd; v.p1ws = p1ws;
        v.e_wen = ewen; v.e_addr = eaddr; v.chk_addr = chka;
        v.e_r0 = er0; v.e_rd0 = erd0; v.e_r1 = er1; v.e_rd1 = erd1;
        v.e_busy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), check on the
    // falling edge, then advance to just after the next rising edge.
    task automatic apply_check(input vec_t v, input string tag);
        reset    = v.rst;
        p0_valid = v.p0v; p0_addr = v.p0a; p0_wdata = v.p0wd; p0_wstrb = v.p0ws;
        p1_valid = v.p1v; p1_addr = v.p1a; p1_wdata = v.p1wd; p1_wstrb = v.p1ws;
        @(negedge clk);
        chk({tag, ".mem_wen"},  32'(mem_wen),  32'(v.e_wen));
        if (v.chk_addr) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
        chk({tag, ".p0_ready"}, 32'(p0_ready), 32'(v.e_r0));
        chk({tag, ".p0_rdata"}, p0_rdata,      v.e_rd0);
        chk({tag, ".p1_ready"}, 32'(p1_ready), 32'(v.e_r1));
        chk({tag, ".p1_rdata"}, p1_rdata,      v.e_rd1);
        chk({tag, ".busy"},     32'(busy),     32'(v.e_busy));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [14];

    initial begin
        n_checks = 0;
        n_errors = 0;
        tb_load  = 1'b1;
        reset    = 1'b1;
        p0_valid = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
        p1_valid = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;

        //         rst p0v p0a      p0wd          p0ws    p1v p1a      p1wd          p1ws     wen      addr chk r0 rd0            r1 rd1            busy
        tbl[0]  = mkv(N, Y, 32'h08, '0,           '0,     N, '0,      '0,           '0,      '0,      5'd2, Y, N, '0,            N, '0,            N);
        tbl[1]  = mkv(N, Y, 32'h08, '0,           '0,     N, '0,      '0,           '0,      '0,      '0,   N, Y, 32'hDEADBEEF, N, '0,            Y);
        tbl[2]  = mkv(N, N, '0,     '0,           '0,     Y, 32'h10, 32'h11223344, 4'b0011, 4'b0011, 5'd4, Y, N, '0,            N, '0,            N);
        tbl[3]  = mkv(N, N, '0,     '0,           '0,     Y, 32'h10, 32'h11223344, 4'b0011, '0,      '0,   N, N, '0,            Y, 32'hAABBCCDD, Y);
        tbl[4]  = mkv(N, N, '0,     '0,           '0,     Y, 32'h10, '0,           '0,      '0,      5'd4, Y, N, '0,            N, '0,            N);
        tbl[5]  = mkv(N, N, '0,     '0,           '0,     Y, 32'h10, '0,           '0,      '0,      '0,   N, N, '0,            Y, 32'hAABB3344, Y);
        tbl[6]  = mkv(N, Y, 32'h84, 32'hCAFEF00D, 4'hF,   N, '0,      '0,           '0,      4'hF,    5'd1, Y, N, '0,            N, '0,            N);
        tbl[7]  = mkv(N, Y, 32'h84, 32'hCAFEF00D, 4'hF,   N, '0,      '0,           '0,      '0,      '0,   N, Y, 32'h10000001, N, '0,            Y);
        tbl[8]  = mkv(N, Y, 32'h04, '0,           '0,     N, '0,      '0,           '0,      '0,      5'd1, Y, N, '0,            N, '0,            N);
        tbl[9]  = mkv(N, Y, 32'h04, '0,           '0,     N, '0,      '0,           '0,      '0,      '0,   N, Y, 32'hCAFEF00D, N, '0,            Y);
        tbl[10] = mkv(N, N, '0,     '0,           '0,     N, '0,      '0,           '0,      '0,      '0,   N, N, '0,            N, '0,            N);
        // p1 drops valid during RESP and still gets its ready
        tbl[11] = mkv(N, N, '0,     '0,           '0,     Y, 32'h0B, '0,           '0,      '0,      5'd2, Y, N, '0,            N, '0,            N);
        tbl[12] = mkv(N, N, '0,     '0,           '0,     N, '0,      '0,           '0,      '0,      '0,   N, N, '0,            Y, 32'hDEADBEEF, Y);
        tbl[13] = mkv(N, N, '0,     '0,           '0,     N, '0,      '0,           '0,      '0,      '0,   N, N, '0,            N, '0,            N);

        @(posedge clk);
        #1;
        tb_load = 1'b0;
        @(negedge clk);
        chk("rst.p0_ready", 32'(p0_ready), 32'd0);
        chk("rst.p1_ready", 32'(p1_ready), 32'd0);
        chk("rst.busy",     32'(busy),     32'd0);
        chk("rst.mem_wen",  32'(mem_wen),  32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) apply_check(tbl[i], $sformatf("tbl%0d", i));

        // Both ports valid continuously from reset: grants alternate p0, p1.
        for (int c = 0; c < 2; c++)
            apply_check(mkv(Y, Y, 32'h08, '0, '0, Y, 32'h10, '0, '0,
                            '0, '0, N, N, '0, N, '0, N), $sformatf("alt_rst%0d", c));
        for (int c = 0; c < 8; c++)
            apply_check(mkv(N, Y, 32'h08, '0, '0, Y, 32'h10, '0, '0,
                            '0, (c % 4 == 0) ? 5'd2 : 5'd4, (c % 2 == 0),
                            (c % 4 == 1), (c % 4 == 1) ? 32'hDEADBEEF : 32'h0,
                            (c % 4 == 3), (c % 4 == 3) ? 32'hAABB3344 : 32'h0,
                            (c % 2 == 1)), $sformatf("alt%0d", c));

        // Reset in the RESP cycle of a p0 read: no ready, and the next tie goes to p0.
        apply_check(mkv(N, Y, 32'h08, '0, '0, N, '0, '0, '0, '0, 5'd2, Y, N, '0, N, '0, N), "abort_grant");
        apply_check(mkv(Y, Y, 32'h08, '0, '0, N, '0, '0, '0, '0, '0,   N, N, '0, N, '0, N), "abort_resp");
        apply_check(mkv(N, N, '0,     '0, '0, N, '0, '0, '0, '0, '0,   N, N, '0, N, '0, N), "abort_after");
        apply_check(mkv(N, Y, 32'h08, '0, '0, Y, 32'h10, '0, '0, '0, 5'd2, Y, N, '0, N, '0, N), "abort_tie");
        apply_check(mkv(N, Y, 32'h08, '0, '0, Y, 32'h10, '0, '0, '0, '0, N, Y, 32'hDEADBEEF, N, '0, Y), "abort_tie_rsp");
        apply_check(mkv(N, N, '0,     '0, '0, N, '0, '0, '0, '0, '0,   N, N, '0, N, '0, N), "abort_idle");

        // p0 re-requests right after its ready while p1 arrives: p1 is served first.
        apply_check(mkv(N, Y, 32'h08, '0, '0, N, '0,     '0, '0, '0, 5'd2, Y, N, '0, N, '0, N), "rr_g0");
        apply_check(mkv(N, Y, 32'h08, '0, '0, Y, 32'h10, '0, '0, '0, '0,   N, Y, 32'hDEADBEEF, N, '0, Y), "rr_r0");
        apply_check(mkv(N, Y, 32'h08, '0, '0, Y, 32'h10, '0, '0, '0, 5'd4, Y, N, '0, N, '0, N), "rr_g1");
        apply_check(mkv(N, Y, 32'h08, '0, '0, Y, 32'h10, '0, '0, '0, '0,   N, N, '0, Y, 32'hAABB3344, Y), "rr_r1");
        apply_check(mkv(N, Y, 32'h08, '0, '0, N, '0,     '0, '0, '0, 5'd2, Y, N, '0, N, '0, N), "rr_g0b");
        apply_check(mkv(N, Y, 32'h08, '0, '0, N, '0,     '0, '0, '0, '0,   N, Y, 32'hDEADBEEF, N, '0, Y), "rr_r0b");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
